countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter with start/done handshake; the decrementing counterpart
//   of the PC incrementer. Times multi-cycle operations (mul/div, stall windows)
//   in the MIPS core: the controller loads a cycle count, and the block signals
//   done after that many enabled cycles. Counter is saturating: never wraps below 0.
// PARAMETERS
//   WIDTH  32  width of load_value and count
// PORTS
//   clk         in   1      system clock, rising-edge active
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      load load_value and begin counting (accepted in IDLE/DONE only)
//   load_value  in   WIDTH  number of enabled cycles to count
//   enable      in   1      decrement qualifier; 0 = pause (count holds)
//   abort       in   1      cancel; return to IDLE with no done
//   done_ack    in   1      consumer acknowledges done
//   count       out  WIDTH  remaining cycles (registered)
//   busy        out  1      1 while in RUN
//   done        out  1      1 while in DONE (level, held until done_ack/start/abort)
// BEHAVIOUR
//   - One clock domain (clk). rst_n asserted (0) asynchronously forces:
//     state=IDLE, count=0, busy=0, done=0. Deassertion takes effect at the next clk edge.
//   - All outputs are registered; no combinational input-to-output paths.
//   - FSM states: IDLE, RUN, DONE. Priority within a cycle: abort > start > enable/done_ack.
//   - IDLE: start=1 with V=load_value:
//       V!=0 -> count<=V, busy<=1, go RUN.
//       V==0 -> count<=0, done<=1, go DONE (done asserted 1 cycle after start).
//     Otherwise everything holds.
//   - RUN: enable=1 and count>1 -> count<=count-1.
//     enable=1 and count==1 -> count<=0, busy<=0, done<=1, go DONE.
//     enable=0 -> count holds. start is ignored in RUN; reload requires abort first.
//   - Latency: with enable held at 1, done rises exactly V cycles after the cycle
//     following the start edge (start edge N, busy at N+1, done at N+1+V).
//   - DONE: done=1, busy=0, count=0. done_ack=1 -> done<=0, go IDLE.
//     start=1 in DONE is an implicit ack plus new start (same rules as IDLE),
//     so back-to-back operations have no idle bubble. start wins over done_ack.
//   - abort=1 in any state -> state<=IDLE, count<=0, busy<=0, done<=0 at the next edge;
//     overrides start, enable and done_ack in the same cycle.
//   - Arithmetic: count is unsigned WIDTH bits. Decrement only occurs when count>=1,
//     so no wrap from 0 to all-ones. load_value=2^WIDTH-1 is legal and counts fully.
//   - Reset mid-RUN discards the operation; no done is produced.
// TESTING
//   1. Reset: rst_n=0 mid-RUN (count=7) -> count=0, busy=0, done=0 immediately, without a clk edge.
//   2. start, V=5, enable=1 continuously -> busy 5 cycles, count 5,4,3,2,1, then count=0, done=1
//      held until done_ack; after done_ack, done=0 and state is IDLE.
//   3. V=4 with enable toggling 1,0,1,0,... -> count holds on enable=0 cycles; done rises after
//      4 enabled cycles (8 clks). Start with V=0 -> done=1 on next cycle, busy never 1.
//   4. abort while count=3; abort+start together in IDLE -> IDLE, count=0, done never asserts;
//      start with V=9 while in RUN -> ignored, count unaffected.
//   5. In DONE, start with V=2 and done_ack same cycle -> done=0, busy=1, count=2 next cycle;
//      WIDTH=8, V=8'hFF -> exactly 255 enabled cycles to done, count never shows 8'hFF after 0.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable, saturating down-counter with a start/done handshake.
// It signals done after the loaded number of enabled cycles.
module countdown_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    input  logic             done_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; abort dominates, then start, then enable/done_ack
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        busy_s  = busy_r;
        done_s  = done_r;
        if (abort) begin
            state_s = ST_IDLE;
            count_s = CNT_ZERO;
            busy_s  = 1'b0;
            done_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // A zero load completes immediately instead of entering RUN
                        if (load_value != CNT_ZERO) begin
                            state_s = ST_RUN;
                            count_s = load_value;
                            busy_s  = 1'b1;
                            done_s  = 1'b0;
                        end else begin
                            state_s = ST_DONE;
                            count_s = CNT_ZERO;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end
                    end else if ((state_r == ST_DONE) && done_ack) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b0;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (count_r > CNT_ONE) begin
                            count_s = count_r - CNT_ONE;
                        end else begin
                            // Last enabled cycle; also catches a stray zero without wrapping
                            state_s = ST_DONE;
                            count_s = CNT_ZERO;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = CNT_ZERO;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end
            endcase
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (WIDTH=8): directed steps plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] load_value;
    logic         enable;
    logic         abort;
    logic         done_ack;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining cycles plus two status flags
    int m_cnt;
    bit m_busy;
    bit m_done;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_value (load_value),
        .enable     (enable),
        .abort      (abort),
        .done_ack   (done_ack),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".count"}, int'(count), m_cnt);
        check_val({tag, ".busy"},  int'(busy),  int'(m_busy));
        check_val({tag, ".done"},  int'(done),  int'(m_done));
    endtask

    // Model one clock edge from the rules: abort > start (when not busy) > enable/ack
    task automatic model_edge(input bit s, input int v, input bit e, input bit a, input bit k);
        if (a) begin
            m_cnt = 0; m_busy = 0; m_done = 0;
        end else if (s && !m_busy) begin
            if (v == 0) begin
                m_cnt = 0; m_busy = 0; m_done = 1;
            end else begin
                m_cnt = v; m_busy = 1; m_done = 0;
            end
        end else if (m_busy) begin
            if (e) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end else if (m_done && k) begin
            m_done = 0;
        end
    endtask

    task automatic cyc(input bit s, input int v, input bit e, input bit a, input bit k,
                       input string tag);
        start = s; load_value = v[W-1:0]; enable = e; abort = a; done_ack = k;
        @(posedge clk);
        model_edge(s, v, e, a, k);
        #1;
        check_all(tag);
    endtask

    initial begin
        int prev_cnt;
        int cycles;
        rst_n = 1'b0; start = 1'b0; load_value = '0; enable = 1'b0;
        abort = 1'b0; done_ack = 1'b0;
        m_cnt = 0; m_busy = 0; m_done = 0;
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset");

        // Async reset mid-RUN with count=7
        cyc(1, 7, 0, 0, 0, "load7");
        cyc(0, 0, 0, 0, 0, "hold7");
        check_val("hold7.explicit", int'(count), 7);
        #2;
        rst_n = 1'b0;
        #1;
        m_cnt = 0; m_busy = 0; m_done = 0;
        check_all("async_reset");
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // V=5 with continuous enable, done held until ack
        cyc(1, 5, 1, 0, 0, "v5.start");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, "v5.run");
        check_val("v5.done_level", int'(done), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "v5.done_hold");
        cyc(0, 0, 0, 0, 1, "v5.ack");
        check_val("v5.after_ack", int'(done), 0);

        // V=4 with enable toggling
        cyc(1, 4, 0, 0, 0, "v4.start");
        for (int i = 0; i < 8; i++) cyc(0, 0, (i % 2) == 0, 0, 0, "v4.toggle");
        check_val("v4.done_after_8", int'(done), 1);
        cyc(0, 0, 0, 0, 1, "v4.ack");

        // V=0: done next cycle, busy never set
        cyc(1, 0, 1, 0, 0, "v0.start");
        check_val("v0.done", int'(done), 1);
        cyc(0, 0, 0, 0, 1, "v0.ack");

        // Abort at count=3, abort+start in IDLE, start ignored in RUN
        cyc(1, 6, 1, 0, 0, "ab.start");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "ab.run");
        check_val("ab.count3", int'(count), 3);
        cyc(0, 0, 1, 1, 0, "ab.abort");
        cyc(1, 5, 1, 1, 0, "ab.abort_start");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "ab.quiet");
        cyc(1, 6, 0, 0, 0, "ign.start");
        cyc(1, 9, 1, 0, 0, "ign.restart");
        check_val("ign.count", int'(count), 5);
        cyc(0, 0, 0, 1, 0, "ign.abort");

        // Back-to-back: start + done_ack in DONE
        cyc(1, 1, 1, 0, 0, "b2b.start");
        cyc(0, 0, 1, 0, 0, "b2b.finish");
        cyc(1, 2, 0, 0, 1, "b2b.restart");
        check_val("b2b.busy", int'(busy), 1);
        check_val("b2b.count", int'(count), 2);
        cyc(0, 0, 0, 1, 0, "b2b.abort");

        // Full-range load: exactly 255 enabled cycles
        cyc(1, 255, 1, 0, 0, "ff.start");
        cycles = 0;
        prev_cnt = 255;
        while (!done && cycles < 300) begin
            cyc(0, 0, 1, 0, 0, "ff.run");
            cycles++;
            if (prev_cnt == 0) check_val("ff.no_wrap", int'(count == 8'hFF), 0);
            prev_cnt = int'(count);
        end
        check_val("ff.cycles", cycles, 255);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, "ff.saturate");
        cyc(0, 0, 0, 0, 1, "ff.ack");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit s, e, a, k;
            int v;
            s = ($urandom_range(0, 5) == 0);
            v = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
            e = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 40) == 0);
            k = ($urandom_range(0, 2) == 0);
            cyc(s, v, e, a, k, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
